// File: rtl/sha_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha_padder
// Purpose  : SHA-2 message padder. Packs a 64-bit byte stream into 512-bit or
//            1024-bit message blocks, appends the 0x80 marker, zero fill and
//            the big-endian bit-length field, and emits blocks as 512-bit beats.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef CODEC_POS
`define CODEC_POS 0
`endif

module sha_padder #(
   parameter int C_S_AXIS_DATA_WIDTH = 64,
   parameter int C_M_AXIS_DATA_WIDTH = 512,
   parameter int C_AXIS_TUSER_WIDTH  = 128
) (
   input  logic                             axis_aclk,
   input  logic                             axis_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast
);

   localparam logic [15:0] C_SHA2_224    = 16'h9320;  // varint 0x93 0x20 as {low, next}
   localparam logic [15:0] C_SHA2_256    = 16'h0012;
   localparam logic [15:0] C_SHA2_384    = 16'h0020;
   localparam logic [15:0] C_SHA2_512    = 16'h0013;
   localparam logic [63:0] C_MARKER_WORD = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_PAD  = 2'd2,
      S_EMIT = 2'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [63:0]   r_buf [16];
   logic [60:0]   r_count;
   logic [3:0]    r_widx;
   logic [127:0]  r_tuser;
   logic          r_mode;        // 1: 1024-bit blocks (SHA-384/512)
   logic          r_more;        // block emitted mid-message, return to FILL
   logic          r_pad_pend;    // an extra padding block follows
   logic          r_mark_pend;   // 0x80 marker still owed to the padding block
   logic          r_half;        // second 512-bit beat of a 1024-bit block
   logic          r_run;         // holds tready low until the first clock after reset

   logic [15:0]   w_codec;
   logic          w_mode_in, w_mode, w_accept, w_full_beat, w_at_end;
   logic          w_defer, w_mark_next, w_fits;
   logic [3:0]    w_nbytes, w_widx, w_last_word, w_len_word, w_mark_word;
   logic [60:0]   w_count_nxt;
   logic [63:0]   w_bitlen, w_word;

   // Codec decode: only the block size matters here (224/256 vs 384/512)
   always_comb begin
      w_codec = s_axis_tuser[`CODEC_POS+15:`CODEC_POS];
      if (s_axis_tuser[`CODEC_POS+7:`CODEC_POS] >= 8'h80)
         w_codec = {s_axis_tuser[`CODEC_POS+7:`CODEC_POS], s_axis_tuser[`CODEC_POS+15:`CODEC_POS+8]};
      case (w_codec)
         C_SHA2_224: w_mode_in = 1'b0;
         C_SHA2_256: w_mode_in = 1'b0;
         C_SHA2_384: w_mode_in = 1'b1;
         C_SHA2_512: w_mode_in = 1'b1;
         default:    w_mode_in = 1'b0;
      endcase
   end

   // Beat geometry: byte count, word placement, marker location and length fit
   always_comb begin
      w_nbytes = 4'd0;
      for (int i = 0; i < 8; i++)
         w_nbytes = w_nbytes + {3'd0, s_axis_tkeep[i]};
      w_mode      = (r_state == S_IDLE) ? w_mode_in : r_mode;
      w_widx      = (r_state == S_IDLE) ? 4'd0 : r_widx;
      w_last_word = w_mode ? 4'd15 : 4'd7;
      w_len_word  = w_mode ? 4'd14 : 4'd7;
      w_accept    = s_axis_tvalid & s_axis_tready;
      w_full_beat = (w_nbytes == 4'd8);
      w_at_end    = (w_widx == w_last_word);
      // a full tlast beat pushes the marker to byte 0 of the following word
      w_mark_word = w_full_beat ? (w_widx + 4'd1) : w_widx;
      w_defer     = s_axis_tlast & w_full_beat & w_at_end;
      w_mark_next = s_axis_tlast & w_full_beat & ~w_at_end;
      w_fits      = ~w_defer & (w_mark_word < w_len_word);
      w_count_nxt = r_count + {57'd0, w_nbytes};
      w_bitlen    = {w_count_nxt, 3'b000};
      w_word      = 64'd0;
      for (int b = 0; b < 8; b++) begin
         if (s_axis_tkeep[7-b])
            w_word[63-8*b -: 8] = s_axis_tdata[63-8*b -: 8];
         else if (s_axis_tlast && (w_nbytes == 4'(b)))
            w_word[63-8*b -: 8] = 8'h80;
      end
   end

   // State register
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_FILL: begin
            if (w_accept)
               w_state_nxt = (s_axis_tlast || w_at_end) ? S_EMIT : S_FILL;
         end
         S_PAD: w_state_nxt = S_EMIT;
         S_EMIT: begin
            if (m_axis_tready && (!r_mode || r_half)) begin
               if (r_more)
                  w_state_nxt = S_FILL;
               else if (r_pad_pend)
                  w_state_nxt = S_PAD;
               else
                  w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Block buffer, byte counter and per-message flags
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         for (int i = 0; i < 16; i++) r_buf[i] <= 64'd0;
         r_count     <= '0;
         r_widx      <= '0;
         r_tuser     <= '0;
         r_mode      <= 1'b0;
         r_more      <= 1'b0;
         r_pad_pend  <= 1'b0;
         r_mark_pend <= 1'b0;
         r_half      <= 1'b0;
         r_run       <= 1'b0;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            S_IDLE, S_FILL: begin
               if (w_accept) begin
                  if (r_state == S_IDLE) begin
                     r_tuser <= s_axis_tuser;
                     r_mode  <= w_mode_in;
                  end
                  r_count       <= w_count_nxt;
                  r_buf[w_widx] <= w_word;
                  if (s_axis_tlast) begin
                     if (w_mark_next) r_buf[w_mark_word] <= C_MARKER_WORD;
                     if (w_fits)      r_buf[w_last_word] <= w_bitlen;
                     r_more      <= 1'b0;
                     r_pad_pend  <= ~w_fits;
                     r_mark_pend <= w_defer;
                  end else if (w_at_end) begin
                     r_more <= 1'b1;
                  end else begin
                     r_widx <= w_widx + 4'd1;
                  end
               end
            end
            S_PAD: begin
               if (r_mark_pend) r_buf[0] <= C_MARKER_WORD;
               r_buf[r_mode ? 15 : 7] <= {r_count, 3'b000};
               r_pad_pend  <= 1'b0;
               r_mark_pend <= 1'b0;
            end
            S_EMIT: begin
               if (m_axis_tready) begin
                  if (r_mode && !r_half) begin
                     r_half <= 1'b1;
                  end else begin
                     // block consumed: clear so the next block starts zero-filled
                     r_half <= 1'b0;
                     for (int i = 0; i < 16; i++) r_buf[i] <= 64'd0;
                     r_widx <= '0;
                     r_more <= 1'b0;
                     if (!r_more && !r_pad_pend) r_count <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign s_axis_tready = r_run & ((r_state == S_IDLE) | (r_state == S_FILL));
   assign m_axis_tvalid = (r_state == S_EMIT);
   assign m_axis_tlast  = (r_state == S_EMIT) & ~r_more & ~r_pad_pend & (~r_mode | r_half);
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tdata  = r_half ?
      {r_buf[8], r_buf[9], r_buf[10], r_buf[11], r_buf[12], r_buf[13], r_buf[14], r_buf[15]} :
      {r_buf[0], r_buf[1], r_buf[2],  r_buf[3],  r_buf[4],  r_buf[5],  r_buf[6],  r_buf[7]};

endmodule

`default_nettype wire

// File: tb/tb_sha_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_padder
// Purpose  : Directed self-checking bench for sha_padder.
// Revision : 1.0 - initial release
// ============================================================================

module tb_sha_padder;

   logic          axis_aclk = 1'b0;
   logic          axis_resetn = 1'b0;
   logic [63:0]   s_axis_tdata = '0;
   logic [7:0]    s_axis_tkeep = '0;
   logic [127:0]  s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [511:0]  m_axis_tdata;
   logic [127:0]  m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;

   int checks = 0;
   int errors = 0;

   sha_padder dut (
      .axis_aclk     (axis_aclk),
      .axis_resetn   (axis_resetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 axis_aclk = ~axis_aclk;

   // Drive one input beat and hold it until accepted (bounded wait)
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [127:0] u, output logic ok);
      int n = 0;
      s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && n < 50) begin @(negedge axis_aclk); n++; end
      ok = s_axis_tready;
      @(negedge axis_aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // Wait for one output beat and accept it (bounded wait)
   task automatic get_beat(output logic [511:0] d, output logic l,
                           output logic [127:0] u, output logic ok);
      int n = 0;
      m_axis_tready = 1'b1;
      while (!m_axis_tvalid && n < 50) begin @(negedge axis_aclk); n++; end
      ok = m_axis_tvalid; d = m_axis_tdata; l = m_axis_tlast; u = m_axis_tuser;
      @(negedge axis_aclk);
      m_axis_tready = 1'b0;
   endtask

   function automatic logic [63:0] mkword(input int j);
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[63-8*b -: 8] = 8'(8*j + b);
      return w;
   endfunction

   task automatic test_reset;
      repeat (3) @(negedge axis_aclk);
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b exp=0", s_axis_tready); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
      checks++; if (m_axis_tdata !== 512'd0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
      checks++; if (m_axis_tuser !== 128'd0) begin errors++; $display("FAIL rst_tuser got=%h exp=0", m_axis_tuser); end
      axis_resetn = 1'b1;
      #1;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_early got=%b exp=0", s_axis_tready); end
      @(negedge axis_aclk);
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got=%b exp=1", s_axis_tready); end
   endtask

   task automatic test_abc_256(input string tag);
      logic [511:0] d, e; logic l, ok, okr; logic [127:0] u;
      e = '0; e[511:448] = 64'h6162_6380_0000_0000; e[63:0] = 64'h18;
      send_beat(64'h6162_6300_0000_0000, 8'hE0, 1'b1, 128'h12, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b exp=1", tag, ok); end
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL %s_latency tvalid got=%b exp=1", tag, m_axis_tvalid); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL %s_stall tready got=%b exp=0", tag, s_axis_tready); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e) begin errors++; $display("FAIL %s_data got=%h exp=%h", tag, d, e); end
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL %s_tlast got=%b exp=1", tag, l); end
      checks++; if (u !== 128'h12) begin errors++; $display("FAIL %s_tuser got=%h exp=12", tag, u); end
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got=%b exp=1", tag, s_axis_tready); end
   endtask

   task automatic test_empty;
      logic [511:0] d, e; logic l, ok, okr; logic [127:0] u;
      e = '0; e[511:448] = 64'h8000_0000_0000_0000;
      send_beat(64'h0, 8'h00, 1'b1, 128'h12, ok);
      get_beat(d, l, u, okr);
      checks++; if (ok !== 1'b1 || okr !== 1'b1 || d !== e) begin errors++; $display("FAIL empty_data got=%h exp=%h", d, e); end
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL empty_tlast got=%b exp=1", l); end
   endtask

   task automatic test_56;
      logic [511:0] d, e1, e2; logic l, ok, okr; logic [127:0] u; int bad = 0;
      e1 = '0; e2 = '0;
      for (int j = 0; j < 7; j++) e1[511-64*j -: 64] = mkword(j);
      e1[63:0] = 64'h8000_0000_0000_0000;
      e2[63:0] = 64'h1C0;
      for (int j = 0; j < 7; j++) begin
         send_beat(mkword(j), 8'hFF, (j == 6), 128'h12, ok);
         if (ok !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b56_accept got=%0d stalls exp=0", bad); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e1) begin errors++; $display("FAIL b56_blk1 got=%h exp=%h", d, e1); end
      checks++; if (l !== 1'b0) begin errors++; $display("FAIL b56_blk1_tlast got=%b exp=0", l); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e2) begin errors++; $display("FAIL b56_blk2 got=%h exp=%h", d, e2); end
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL b56_blk2_tlast got=%b exp=1", l); end
   endtask

   task automatic test_64;
      logic [511:0] d, e1, e2; logic l, ok, okr; logic [127:0] u; int bad = 0;
      e1 = '0; e2 = '0;
      for (int j = 0; j < 8; j++) e1[511-64*j -: 64] = mkword(j);
      e2[511:448] = 64'h8000_0000_0000_0000;
      e2[63:0]    = 64'h200;
      for (int j = 0; j < 8; j++) begin
         send_beat(mkword(j), 8'hFF, (j == 7), 128'h12, ok);
         if (ok !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b64_accept got=%0d stalls exp=0", bad); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e1) begin errors++; $display("FAIL b64_blk1 got=%h exp=%h", d, e1); end
      checks++; if (l !== 1'b0) begin errors++; $display("FAIL b64_blk1_tlast got=%b exp=0", l); end
      checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin errors++; $display("FAIL b64_pad_cycle got tvalid=%b tready=%b exp 0/0", m_axis_tvalid, s_axis_tready); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e2) begin errors++; $display("FAIL b64_blk2 got=%h exp=%h", d, e2); end
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL b64_blk2_tlast got=%b exp=1", l); end
   endtask

   task automatic test_sha512_abc;
      logic [511:0] d, e1, e2; logic l, ok, okr; logic [127:0] u;
      e1 = '0; e1[511:448] = 64'h6162_6380_0000_0000;
      e2 = '0; e2[63:0] = 64'h18;
      send_beat(64'h6162_6300_0000_0000, 8'hE0, 1'b1, 128'h13, ok);
      get_beat(d, l, u, okr);
      checks++; if (ok !== 1'b1 || okr !== 1'b1 || d !== e1) begin errors++; $display("FAIL s512_beat1 got=%h exp=%h", d, e1); end
      checks++; if (l !== 1'b0) begin errors++; $display("FAIL s512_beat1_tlast got=%b exp=0", l); end
      checks++; if (u !== 128'h13) begin errors++; $display("FAIL s512_tuser got=%h exp=13", u); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL s512_mid_tready got=%b exp=0", s_axis_tready); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e2) begin errors++; $display("FAIL s512_beat2 got=%h exp=%h", d, e2); end
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL s512_beat2_tlast got=%b exp=1", l); end
   endtask

   task automatic test_backpressure;
      logic [511:0] d, e; logic l, ok, okr; logic [127:0] u; int bad = 0;
      e = '0; e[511:448] = 64'h6162_6380_0000_0000; e[63:0] = 64'h18;
      send_beat(64'h6162_6300_0000_0000, 8'hE0, 1'b1, 128'h12, ok);
      for (int c = 0; c < 5; c++) begin
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e || m_axis_tlast !== 1'b1 ||
             m_axis_tuser !== 128'h12 || s_axis_tready !== 1'b0) bad++;
         @(negedge axis_aclk);
      end
      checks++; if (ok !== 1'b1 || bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
      get_beat(d, l, u, okr);
      checks++; if (okr !== 1'b1 || d !== e || l !== 1'b1) begin errors++; $display("FAIL bp_release got=%h exp=%h", d, e); end
   endtask

   task automatic test_reset_mid_emit;
      logic ok; int bad = 0;
      send_beat(64'h6162_6300_0000_0000, 8'hE0, 1'b1, 128'h12, ok);
      checks++; if (ok !== 1'b1 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rme_emit got tvalid=%b exp=1", m_axis_tvalid); end
      axis_resetn = 1'b0;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 512'd0) begin errors++; $display("FAIL rme_drop got tvalid=%b exp=0", m_axis_tvalid); end
      @(negedge axis_aclk);
      axis_resetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge axis_aclk);
         if (m_axis_tvalid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rme_no_partial got=%0d valid cycles exp=0", bad); end
   endtask

   initial begin
      test_reset();
      test_abc_256("abc");
      test_empty();
      test_56();
      test_64();
      test_sha512_abc();
      test_abc_256("b2b");
      test_backpressure();
      test_reset_mid_emit();
      test_abc_256("post_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
